// File: rtl/alb_word_ctrl_if.sv
// alb_word_ctrl_if
// Operand/flag bus between a word controller and one 4-bit ALB.
//   R, S  : nibble operands        (controller -> ALB)
//   CI    : carry into the nibble  (controller -> ALB)
//   I     : ALB function select    (controller -> ALB)
//   F     : nibble result          (ALB -> controller)
//   CO, VO, NO, ZO : carry, overflow, negative, zero of the nibble
// master = the controller (initiating end), slave = the ALB.
interface alb_word_ctrl_if;
  logic [3:0] R;
  logic [3:0] S;
  logic       CI;
  logic [1:0] I;
  logic [3:0] F;
  logic       CO;
  logic       VO;
  logic       NO;
  logic       ZO;

  modport master (output R, S, CI, I, input F, CO, VO, NO, ZO);
  modport slave  (input R, S, CI, I, output F, CO, VO, NO, ZO);
endinterface

// File: rtl/alb_word_ctrl.sv
// alb_word_ctrl
// Runs a W-bit (W = 4*N_NIB) operation on a 4-bit ALB, one nibble per step,
// least significant nibble first, chaining the ALB carry between nibbles.
// Ports:
//   clk, reset (async, active low)
//   start, op[1:0], a_in[W], b_in[W], cin : request, sampled only when idle
//   busy, done                            : handshake status
//   result[W], c_out, v_out, n_out, z_out : assembled word result and flags
//   alb (master modport)                  : operand/flag bus to the ALB
module alb_word_ctrl #(
  parameter int N_NIB   = 4,
  parameter int ALB_LAT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [4*N_NIB-1:0]   a_in,
  input  logic [4*N_NIB-1:0]   b_in,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*N_NIB-1:0]   result,
  output logic                 c_out,
  output logic                 v_out,
  output logic                 n_out,
  output logic                 z_out,
  alb_word_ctrl_if.master      alb
);

  localparam int W     = 4 * N_NIB;
  localparam int NIB_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;
  localparam logic [NIB_W-1:0] LAST_NIB  = NIB_W'(N_NIB - 1);
  // The WAIT counter starts at ALB_LAT-1 so the last WAIT cycle is the one
  // where it reads zero.
  localparam logic [1:0]       WAIT_INIT = 2'((ALB_LAT > 0) ? ALB_LAT - 1 : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state_reg;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [1:0]       op_reg;
  logic             cin_reg;
  logic [NIB_W-1:0] nib_idx_reg;
  logic [1:0]       wait_cnt_reg;
  logic             zacc_reg;
  logic             carry_reg;
  logic [W-1:0]     res_acc_reg;

  logic [3:0]       a_nib [N_NIB];
  logic [3:0]       b_nib [N_NIB];
  logic [W-1:0]     merged;
  logic             active;
  logic             arith;
  logic             sample;
  logic             last_nib;

  // Nibble views of the latched operands, and the working result with the
  // current ALB output dropped into the active nibble slot.
  genvar gi;
  generate
    for (gi = 0; gi < N_NIB; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[4*gi +: 4];
      assign b_nib[gi] = b_reg[4*gi +: 4];
      assign merged[4*gi +: 4] = (nib_idx_reg == NIB_W'(gi)) ? alb.F
                                                              : res_acc_reg[4*gi +: 4];
    end
  endgenerate

  // Ops 00 (subtract) and 10 (add) use the carry chain; 01/11 are logic ops.
  assign arith    = ~op_reg[0];
  assign active   = (state_reg == ISSUE) || (state_reg == WAIT);
  assign last_nib = (nib_idx_reg == LAST_NIB);
  assign sample   = ((state_reg == ISSUE) && (ALB_LAT == 0)) ||
                    ((state_reg == WAIT) && (wait_cnt_reg == 2'd0));

  // ALB inputs decode only from registered state; nothing here depends on
  // the ALB outputs.
  always_comb begin
    alb.R  = 4'd0;
    alb.S  = 4'd0;
    alb.I  = 2'd0;
    alb.CI = 1'b0;
    if (active) begin
      alb.R = a_nib[nib_idx_reg];
      alb.S = b_nib[nib_idx_reg];
      alb.I = op_reg;
      if (arith) begin
        alb.CI = (nib_idx_reg == '0) ? cin_reg : carry_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= '0;
      cin_reg      <= 1'b0;
      nib_idx_reg  <= '0;
      wait_cnt_reg <= '0;
      zacc_reg     <= 1'b0;
      carry_reg    <= 1'b0;
      res_acc_reg  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      c_out        <= 1'b0;
      v_out        <= 1'b0;
      n_out        <= 1'b0;
      z_out        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg       <= a_in;
            b_reg       <= b_in;
            op_reg      <= op;
            cin_reg     <= cin;
            nib_idx_reg <= '0;
            zacc_reg    <= 1'b1;
            busy        <= 1'b1;
            state_reg   <= ISSUE;
          end
        end
        ISSUE: begin
          if (ALB_LAT != 0) begin
            wait_cnt_reg <= WAIT_INIT;
            state_reg    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt_reg != 2'd0) begin
            wait_cnt_reg <= wait_cnt_reg - 2'd1;
          end
        end
        DONE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      // Sampling overrides the per-state next-state choice above.
      if (sample) begin
        res_acc_reg <= merged;
        zacc_reg    <= zacc_reg & alb.ZO;
        carry_reg   <= alb.CO;
        if (last_nib) begin
          result    <= merged;
          c_out     <= arith & alb.CO;
          v_out     <= arith & alb.VO;
          n_out     <= alb.NO;
          z_out     <= zacc_reg & alb.ZO;
          done      <= 1'b1;
          state_reg <= DONE;
        end else begin
          nib_idx_reg <= nib_idx_reg + 1'b1;
          state_reg   <= ISSUE;
        end
      end
    end
  end

endmodule

// File: doc/alb_word_ctrl.md
# alb_word_ctrl

Control device that runs multi-word operations on the 4-bit ALB operation device. It accepts a wide operation request through a start/busy/done handshake and drives the ALB inputs (R, S, CI, I) one nibble per step, least significant first. Between nibbles it chains ALB carry-out to carry-in, then assembles the wide result and flags. It sits between the datapath sequencer and one ALB instance, as the initiating end of the ALB operand/flag interface.

## Interface
- N_NIB, 4, number of 4-bit nibbles per word; word width W = 4*N_NIB, valid 1..8.
- ALB_LAT, 0, wait cycles between driving a nibble and sampling the ALB outputs; valid 0..3.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request strobe; sampled only in IDLE
- op  in  2  ALB function: 00 S-R-1+CI, 01 S AND R, 10 S+R+CI, 11 NOT(S AND R)
- a_in  in  W  R operand
- b_in  in  W  S operand
- cin  in  1  carry into nibble 0 for arithmetic ops
- busy  out  1  high from the cycle after an accepted start through the DONE cycle
- done  out  1  one-cycle pulse; result and flags valid in this cycle
- result  out  W  assembled F
- c_out, v_out, n_out, z_out  out  1 each  word carry, overflow, negative, zero
- alb_R, alb_S  out  4  nibble operands to the ALB
- alb_CI  out  1  carry to the ALB
- alb_I  out  2  function to the ALB
- alb_F  in  4  ALB result
- alb_CO, alb_VO, alb_NO, alb_ZO  in  1 each  ALB flags

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If start=1, latch a_in, b_in, op and cin.
  - Clear nib_idx, set zacc=1, and go to ISSUE.
- ISSUE:
  - Drive alb_R = a[4*nib_idx +: 4], alb_S = b[4*nib_idx +: 4] and alb_I = op.
  - If ALB_LAT=0, sample the ALB outputs in this cycle. Otherwise go to WAIT.
- WAIT:
  - Hold the ALB inputs and count down ALB_LAT cycles.
  - Sample on the last WAIT cycle.
- Sample actions:
  - Write result[4*nib_idx +: 4] <= alb_F.
  - zacc <= zacc & alb_ZO.
  - carry <= alb_CO.
  - If nib_idx = N_NIB-1, latch the flags and go to DONE. Otherwise increment nib_idx and go to ISSUE.
- alb_CI:
  - Arithmetic ops (op[1] XNOR op[0] = 0 is not used; the ops are 00 and 10): alb_CI = cin for nibble 0 and the registered carry for later nibbles.
  - Logic ops (01, 11): alb_CI = 0.
- Flags:
  - Arithmetic ops: c_out and v_out = alb_CO and alb_VO of the top nibble.
  - Logic ops: c_out = v_out = 0.
  - n_out = alb_NO of the top nibble.
  - z_out = zacc after the final sample.
- DONE: done=1 for exactly one cycle, then go to IDLE. result and flags hold until the next accepted start.
- In IDLE and DONE, alb_R, alb_S, alb_CI and alb_I are driven to 0.
- start while busy=1 is ignored and no request is queued.
- Operands are latched, so changes on a_in, b_in, op or cin after acceptance have no effect.

## Timing
- Reset (asynchronous, immediate, including mid-operation):
  - State goes to IDLE.
  - busy, done, result, c_out, v_out, n_out, z_out = 0.
  - alb_* outputs = 0.
- Each nibble takes 1+ALB_LAT cycles.
- If start is accepted at edge T, then done is high in cycle T + N_NIB*(1+ALB_LAT) + 1.
- With the defaults this is T+5.
- A new start is accepted in the cycle after done, giving a back-to-back throughput of one op per N_NIB*(1+ALB_LAT)+2 cycles.
- Outputs are registered, except that alb_* are decoded from registered state and nib_idx with no combinational path from the alb_* inputs.

## Test plan
Defaults (N_NIB=4, ALB_LAT=0) unless stated.
1. op=10, a=0x00FF, b=0x0001, cin=0 -> result=0x0100, c=0, v=0, n=0, z=0; done 5 cycles after the start edge; alb_CI sequence 0,1,1,0.
2. op=00, a=0x0001, b=0x0001, cin=1 -> result=0x0000, z=1, c=1, v=0, n=0.
3. op=10, a=0x7FFF, b=0x0001, cin=0 -> result=0x8000, v=1, n=1, c=0, z=0.
4. op=01, a=0xF0F0, b=0xFFFF -> result=0xF0F0, c=0, v=0, alb_CI=0 on all nibbles; then op=11 with the same operands -> result=0x0F0F.
5. Assert start again 2 cycles into test 1 with a=0x1111 -> ignored, result still 0x0100. Assert reset low 2 cycles into a new op -> all outputs 0 immediately, no done pulse, and the next start completes normally.
6. ALB_LAT=2, rerun test 1 -> same result and flags; done 13 cycles after start; each nibble's alb_R/alb_S held stable for 3 cycles.
